// File: rtl/checkpoint_seq_pkg.sv
// Shared types and constants for the checkpoint-sequence monitor.
package checkpoint_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StHold,
      StPass,
      StFail
   } state_e;

   localparam logic [1:0] FC_NONE    = 2'd0;
   localparam logic [1:0] FC_TIMEOUT = 2'd1;
   localparam logic [1:0] FC_ABORT   = 2'd2;
   localparam logic [1:0] FC_CFG     = 2'd3;

endpackage

// File: rtl/checkpoint_sync.sv
// WIDTH-bit two-flop synchronizer for the asynchronous checkpoint bus.
module checkpoint_sync #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clock,
   input  logic             resetb,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/checkpoint_seq_monitor.sv
// Steps through a programmed list of (value, mask) checkpoints on a synchronized bus,
// with glitch filtering, per-step timeout, abort and sticky pass/fail reporting.
module checkpoint_seq_monitor
   import checkpoint_seq_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned TO_W   = 24,
   parameter int unsigned STABLE = 2
) (
   input  logic                     clock,
   input  logic                     resetb,
   input  logic                     cfg_we,
   input  logic [$clog2(DEPTH)-1:0] cfg_addr,
   input  logic [WIDTH-1:0]         cfg_value,
   input  logic [WIDTH-1:0]         cfg_mask,
   input  logic [$clog2(DEPTH):0]   cfg_len,
   input  logic [TO_W-1:0]          cfg_timeout,
   input  logic                     start,
   input  logic                     abort,
   input  logic [WIDTH-1:0]         obs,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic                     fail,
   output logic [1:0]               fail_code,
   output logic [$clog2(DEPTH)-1:0] step,
   output logic                     match_pulse,
   output logic [31:0]              cycle_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned HW = $clog2(STABLE + 1);

   logic [WIDTH-1:0] w_obs_s;
   logic [WIDTH-1:0] r_value [DEPTH];
   logic [WIDTH-1:0] r_mask  [DEPTH];
   logic [LW-1:0]    r_len;
   logic [TO_W-1:0]  r_timeout;
   state_e           r_state;
   state_e           w_state_nxt;
   logic [AW-1:0]    r_step;
   logic [HW-1:0]    r_hold_cnt;
   logic [TO_W-1:0]  r_timer;
   logic [31:0]      r_cycle_count;
   logic             r_done;
   logic             r_pass;
   logic             r_fail;
   logic [1:0]       r_fail_code;

   logic          w_active;
   logic          w_match;
   logic          w_len_bad;
   logic          w_start_go;
   logic [HW-1:0] w_hold_inc;
   logic          w_accept;
   logic          w_timeout;
   logic          w_last;

   checkpoint_sync #(
      .WIDTH (WIDTH)
   ) u_sync (
      .clock  (clock),
      .resetb (resetb),
      .i_d    (obs),
      .o_q    (w_obs_s)
   );

   assign w_active   = (r_state == StWait) || (r_state == StHold);
   assign w_match    = ((w_obs_s & r_mask[r_step]) == (r_value[r_step] & r_mask[r_step]));
   assign w_len_bad  = (cfg_len == '0) || (cfg_len > LW'(DEPTH));
   assign w_start_go = start && !w_active;
   assign w_hold_inc = r_hold_cnt + HW'(1);
   // The WAIT cycle itself counts as the first matching cycle.
   assign w_accept   = w_match && (((r_state == StWait) && (STABLE == 1)) ||
                                   ((r_state == StHold) && (w_hold_inc == HW'(STABLE))));
   assign w_timeout  = w_active && (r_timeout != '0) && (r_timer == r_timeout);
   assign w_last     = ({1'b0, r_step} == (r_len - LW'(1)));

   // State register
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: abort > accept > timeout
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle, StPass, StFail: begin
            if (start) w_state_nxt = w_len_bad ? StFail : StWait;
         end
         StWait, StHold: begin
            if (abort)          w_state_nxt = StFail;
            else if (w_accept)  w_state_nxt = w_last ? StPass : StWait;
            else if (w_timeout) w_state_nxt = StFail;
            else                w_state_nxt = w_match ? StHold : StWait;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      busy        = w_active;
      match_pulse = w_accept && !abort;
      done        = r_done;
      pass        = r_pass;
      fail        = r_fail;
      fail_code   = r_fail_code;
      step        = r_step;
      cycle_count = r_cycle_count;
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_value[i] <= '0;
            r_mask[i]  <= '0;
         end
      end else if (cfg_we && !w_active) begin
         r_value[cfg_addr] <= cfg_value;
         r_mask[cfg_addr]  <= cfg_mask;
      end
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_len         <= '0;
         r_timeout     <= '0;
         r_step        <= '0;
         r_hold_cnt    <= '0;
         r_timer       <= '0;
         r_cycle_count <= '0;
         r_done        <= 1'b0;
         r_pass        <= 1'b0;
         r_fail        <= 1'b0;
         r_fail_code   <= FC_NONE;
      end else if (w_start_go) begin
         r_len         <= cfg_len;
         r_timeout     <= cfg_timeout;
         r_step        <= '0;
         r_hold_cnt    <= '0;
         r_timer       <= '0;
         r_cycle_count <= '0;
         r_done        <= w_len_bad;
         r_pass        <= 1'b0;
         r_fail        <= w_len_bad;
         r_fail_code   <= w_len_bad ? FC_CFG : FC_NONE;
      end else if (w_active) begin
         if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 32'd1;
         if (abort) begin
            r_done      <= 1'b1;
            r_fail      <= 1'b1;
            r_fail_code <= FC_ABORT;
         end else if (w_accept) begin
            r_timer    <= '0;
            r_hold_cnt <= '0;
            if (w_last) begin
               r_done <= 1'b1;
               r_pass <= 1'b1;
            end else begin
               r_step <= r_step + AW'(1);
            end
         end else if (w_timeout) begin
            r_done      <= 1'b1;
            r_fail      <= 1'b1;
            r_fail_code <= FC_TIMEOUT;
         end else begin
            r_timer    <= r_timer + TO_W'(1);
            r_hold_cnt <= w_match ? w_hold_inc : '0;
         end
      end
   end

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Directed bench for checkpoint_seq_monitor: sequences, timeout, glitch, mask, abort,
// config error, busy writes and mid-run reset.
module tb_checkpoint_seq_monitor;

   logic        clock = 1'b0;
   logic        resetb = 1'b0;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_addr = '0;
   logic [15:0] cfg_value = '0;
   logic [15:0] cfg_mask = '0;
   logic [3:0]  cfg_len = '0;
   logic [23:0] cfg_timeout = '0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] obs = '0;
   logic        busy;
   logic        done;
   logic        pass;
   logic        fail;
   logic [1:0]  fail_code;
   logic [2:0]  step;
   logic        match_pulse;
   logic [31:0] cycle_count;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   int unsigned pulse_cnt = 0;
   int unsigned base;
   logic [15:0] seq [7];

   checkpoint_seq_monitor #(
      .WIDTH  (16),
      .DEPTH  (8),
      .TO_W   (24),
      .STABLE (2)
   ) dut (
      .clock       (clock),
      .resetb      (resetb),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_value   (cfg_value),
      .cfg_mask    (cfg_mask),
      .cfg_len     (cfg_len),
      .cfg_timeout (cfg_timeout),
      .start       (start),
      .abort       (abort),
      .obs         (obs),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .fail        (fail),
      .fail_code   (fail_code),
      .step        (step),
      .match_pulse (match_pulse),
      .cycle_count (cycle_count)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (match_pulse) pulse_cnt <= pulse_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wr(input int a, input logic [15:0] v, input logic [15:0] m);
      cfg_we    = 1'b1;
      cfg_addr  = a[2:0];
      cfg_value = v;
      cfg_mask  = m;
      cyc(1);
      cfg_we    = 1'b0;
   endtask

   task automatic load_seq();
      for (int i = 0; i < 7; i++) wr(i, seq[i], 16'hFFFF);
   endtask

   task automatic go(input int len, input int to);
      cfg_len     = len[3:0];
      cfg_timeout = to[23:0];
      start       = 1'b1;
      cyc(1);
      start       = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_pass"}, 32'(pass), 0);
      check({tag, "_fail"}, 32'(fail), 0);
      check({tag, "_code"}, 32'(fail_code), 0);
      check({tag, "_step"}, 32'(step), 0);
      check({tag, "_mpulse"}, 32'(match_pulse), 0);
      check({tag, "_cycles"}, cycle_count, 0);
   endtask

   initial begin
      seq = '{16'hAB40, 16'h003E, 16'h0044, 16'h004A, 16'h0050, 16'h0044, 16'hAB51};

      // Reset state
      cyc(2);
      check_all_zero("in_reset");
      resetb = 1'b1;
      cyc(2);
      @(negedge clock);
      check_all_zero("after_reset");

      // Full seven-entry sequence
      load_seq();
      obs = 16'h0000;
      cyc(2);
      base = pulse_cnt;
      go(7, 1000);
      @(negedge clock);
      check("seq_busy_after_start", 32'(busy), 1);
      for (int i = 0; i < 7; i++) begin
         obs = seq[i];
         cyc(20);
      end
      @(negedge clock);
      check("seq_pulses", pulse_cnt - base, 7);
      check("seq_pass", 32'(pass), 1);
      check("seq_fail", 32'(fail), 0);
      check("seq_done", 32'(done), 1);
      check("seq_step", 32'(step), 6);
      check("seq_busy", 32'(busy), 0);

      // Timeout on entry 3 while obs stays at 0x0044
      obs = 16'h0000;
      cyc(2);
      go(7, 1000);
      for (int i = 0; i < 3; i++) begin
         obs = seq[i];
         cyc(20);
      end
      cyc(900);
      @(negedge clock);
      check("to_not_yet_busy", 32'(busy), 1);
      check("to_not_yet_fail", 32'(fail), 0);
      cyc(600);
      @(negedge clock);
      check("to_fail", 32'(fail), 1);
      check("to_code", 32'(fail_code), 1);
      check("to_step", 32'(step), 3);
      check("to_pass", 32'(pass), 0);
      check("to_done", 32'(done), 1);

      // One-cycle glitch rejected, two-cycle value accepted
      wr(0, 16'h1234, 16'hFFFF);
      obs = 16'h5555;
      cyc(3);
      base = pulse_cnt;
      go(1, 0);
      obs = 16'h1234;
      cyc(1);
      obs = 16'h5555;
      cyc(10);
      @(negedge clock);
      check("glitch_no_pulse", pulse_cnt - base, 0);
      check("glitch_busy", 32'(busy), 1);
      obs = 16'h1234;
      cyc(2);
      obs = 16'h5555;
      cyc(6);
      @(negedge clock);
      check("stable_pulse", pulse_cnt - base, 1);
      check("stable_pass", 32'(pass), 1);

      // Masked compare; obs already stable so the run takes exactly 2 cycles
      wr(0, 16'hAB00, 16'hFF00);
      obs = 16'hAB7F;
      cyc(3);
      base = pulse_cnt;
      go(1, 0);
      cyc(4);
      @(negedge clock);
      check("mask_pass", 32'(pass), 1);
      check("mask_pulse", pulse_cnt - base, 1);
      check("mask_cycles", cycle_count, 2);
      check("mask_step", 32'(step), 0);

      // Abort in the same cycle as the final accept
      load_seq();
      obs = 16'h0000;
      cyc(2);
      base = pulse_cnt;
      go(7, 1000);
      for (int i = 0; i < 6; i++) begin
         obs = seq[i];
         cyc(20);
      end
      obs = seq[6];
      cyc(3);
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      @(negedge clock);
      check("abort_fail", 32'(fail), 1);
      check("abort_code", 32'(fail_code), 2);
      check("abort_pass", 32'(pass), 0);
      check("abort_step", 32'(step), 6);
      check("abort_pulses", pulse_cnt - base, 6);
      check("abort_done", 32'(done), 1);

      // Config errors
      go(0, 0);
      @(negedge clock);
      check("len0_fail", 32'(fail), 1);
      check("len0_code", 32'(fail_code), 3);
      check("len0_done", 32'(done), 1);
      cyc(1);
      go(9, 0);
      @(negedge clock);
      check("len9_code", 32'(fail_code), 3);
      check("len9_busy", 32'(busy), 0);

      // Table writes ignored while busy
      obs = 16'h0000;
      cyc(2);
      base = pulse_cnt;
      go(7, 0);
      wr(0, 16'h1111, 16'hFFFF);
      obs = 16'hAB40;
      cyc(8);
      @(negedge clock);
      check("busywr_pulse", pulse_cnt - base, 1);
      check("busywr_step", 32'(step), 1);
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      @(negedge clock);
      check("busywr_abort_code", 32'(fail_code), 2);

      // Reset mid-run clears outputs and discards the table
      obs = 16'h0000;
      cyc(2);
      go(7, 0);
      obs = 16'hAB40;
      cyc(8);
      #2;
      resetb = 1'b0;
      #1;
      check_all_zero("midrst");
      cyc(2);
      resetb = 1'b1;
      obs = 16'h0000;
      cyc(3);
      base = pulse_cnt;
      go(1, 0);
      cyc(4);
      @(negedge clock);
      check("midrst_table_cleared_pass", 32'(pass), 1);
      check("midrst_pulse", pulse_cnt - base, 1);
      check("midrst_cycles", cycle_count, 2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
